// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-ported RAM between the instruction-fetch
// port and the data load/store port; one transaction in flight at a time.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1,
   parameter int PRIO_MODE  = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic              i_gnt_o,
   output logic              i_rvalid_o,
   output logic [DATA_W-1:0] i_rdata_o,
   input  logic              d_req_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   input  logic [3:0]        d_wmask_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_wmask_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic [1:0]        state_o
);
   // Handshake: a port holds req and its fields until it sees gnt high (a
   // one-cycle pulse in the first ACCESS cycle); req is only sampled in IDLE.
   // rvalid is a one-cycle pulse in RESP and never follows a store.

   if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
      $error("mem_arbiter: RD_LATENCY must be in 1..7");
   end

   localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);
   localparam logic       OWN_I    = 1'b0;
   localparam logic       OWN_D    = 1'b1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t            state, state_nxt;
   logic              owner, owner_nxt;
   logic              last_owner, last_owner_nxt;
   logic              pick_d;
   logic [2:0]        cnt, cnt_nxt;
   logic              i_gnt_nxt, d_gnt_nxt, i_rvalid_nxt, d_rvalid_nxt;
   logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt, mem_wdata_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic              mem_en_nxt;
   logic [3:0]        mem_wmask_nxt;

   // A lone requester wins; on a tie either the data port or the port that
   // did not own the previous grant wins.
   always_comb begin
      if (d_req_i != i_req_i) pick_d = d_req_i;
      else if (PRIO_MODE == 1) pick_d = 1'b1;
      else pick_d = (last_owner == OWN_I);
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      cnt_nxt        = cnt;
      i_gnt_nxt      = 1'b0;
      d_gnt_nxt      = 1'b0;
      i_rvalid_nxt   = 1'b0;
      d_rvalid_nxt   = 1'b0;
      i_rdata_nxt    = i_rdata_o;
      d_rdata_nxt    = d_rdata_o;
      mem_en_nxt     = mem_en_o;
      mem_addr_nxt   = mem_addr_o;
      mem_wdata_nxt  = mem_wdata_o;
      mem_wmask_nxt  = mem_wmask_o;
      case (state)
         IDLE: begin
            if (i_req_i || d_req_i) begin
               state_nxt      = ACCESS;
               owner_nxt      = pick_d;
               last_owner_nxt = pick_d;
               cnt_nxt        = CNT_INIT;
               mem_en_nxt     = 1'b1;
               if (pick_d) begin
                  d_gnt_nxt     = 1'b1;
                  mem_addr_nxt  = d_addr_i;
                  mem_wdata_nxt = d_wdata_i;
                  mem_wmask_nxt = d_wmask_i;
               end else begin
                  i_gnt_nxt     = 1'b1;
                  mem_addr_nxt  = i_addr_i;
                  mem_wmask_nxt = 4'b0;
               end
            end
         end
         ACCESS: begin
            // Only a data-port store leaves a non-zero mask latched here.
            if (mem_wmask_o != 4'b0) begin
               state_nxt     = IDLE;
               mem_en_nxt    = 1'b0;
               mem_wmask_nxt = 4'b0;
            end else if (cnt == 3'd0) begin
               state_nxt  = RESP;
               mem_en_nxt = 1'b0;
               if (owner == OWN_D) begin
                  d_rdata_nxt  = mem_rdata_i;
                  d_rvalid_nxt = 1'b1;
               end else begin
                  i_rdata_nxt  = mem_rdata_i;
                  i_rvalid_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         owner       <= OWN_I;
         last_owner  <= OWN_I;
         cnt         <= 3'd0;
         i_gnt_o     <= 1'b0;
         d_gnt_o     <= 1'b0;
         i_rvalid_o  <= 1'b0;
         d_rvalid_o  <= 1'b0;
         i_rdata_o   <= '0;
         d_rdata_o   <= '0;
         mem_en_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_wmask_o <= 4'b0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         last_owner  <= last_owner_nxt;
         cnt         <= cnt_nxt;
         i_gnt_o     <= i_gnt_nxt;
         d_gnt_o     <= d_gnt_nxt;
         i_rvalid_o  <= i_rvalid_nxt;
         d_rvalid_o  <= d_rvalid_nxt;
         i_rdata_o   <= i_rdata_nxt;
         d_rdata_o   <= d_rdata_nxt;
         mem_en_o    <= mem_en_nxt;
         mem_addr_o  <= mem_addr_nxt;
         mem_wdata_o <= mem_wdata_nxt;
         mem_wmask_o <= mem_wmask_nxt;
      end
   end

   assign busy_o  = (state != IDLE);
   assign state_o = state;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single-ported core RAM between the instruction-fetch port (read-only) and the data load/store port.
- Accepts one request at a time and drives the RAM chip-select, address, write data and byte write mask from registers.
- Waits a programmable read latency, then returns read data to the winning port with a one-cycle valid pulse.
- Sits between the core pipeline and mem_RAM.

Parameters:
- ADDR_W, 32, address width (matches API_ADDR_WIDTH).
- DATA_W, 32, data width (matches API_DATA_WIDTH).
- RD_LATENCY, 1, cycles chip-select is held before read data is captured; legal range 1..7.
- PRIO_MODE, 0, 0 = round-robin on ties; 1 = data port has fixed priority.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_req_i  in  1  instruction-fetch read request.
- i_addr_i  in  ADDR_W  fetch byte address.
- i_gnt_o  out  1  fetch request accepted (one-cycle pulse).
- i_rvalid_o  out  1  fetch data valid (one-cycle pulse).
- i_rdata_o  out  DATA_W  fetch read data, held until the next fetch read.
- d_req_i  in  1  data-port request.
- d_addr_i  in  ADDR_W  data byte address.
- d_wdata_i  in  DATA_W  store data.
- d_wmask_i  in  4  byte write mask; 0 = load.
- d_gnt_o  out  1  data request accepted (one-cycle pulse).
- d_rvalid_o  out  1  load data valid (one-cycle pulse; never asserted for stores).
- d_rdata_o  out  DATA_W  load data, held until the next load.
- mem_en_o  out  1  RAM chip select, registered.
- mem_addr_o  out  ADDR_W  RAM address, registered.
- mem_wdata_o  out  DATA_W  RAM write data, registered.
- mem_wmask_o  out  4  RAM write mask, registered.
- mem_rdata_i  in  DATA_W  RAM read data.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - All outputs go to 0; mem_wmask_o = 4'b0.
  - last_owner is set to INSTR, so the data port wins the first round-robin tie.
- Reset asserted mid-transaction:
  - The transaction is aborted and no rvalid is produced.
  - mem_en_o drops asynchronously.
- All mem_* outputs come from flops, so there are no combinational glitches on the RAM, which is sensitive to both clock edges.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - With no request pending, state stays IDLE.
  - On a rising edge with i_req_i or d_req_i high, the arbiter picks the owner, latches addr/wdata/wmask from that port and moves to ACCESS.
  - It also sets mem_en_o = 1, mem_addr_o = address, mem_wdata_o = data, and mem_wmask_o = d_wmask_i (data owner) or 0 (fetch owner).
  - It pulses the owner's gnt_o high for the first ACCESS cycle.
  - Loads the latency counter with RD_LATENCY-1.
- Arbitration:
  - A single requester always wins.
  - When both request and PRIO_MODE=1, the data port wins.
  - When both request and PRIO_MODE=0, the port that is not last_owner wins.
  - last_owner updates on every grant.
  - The losing request stays pending and is re-evaluated in the next IDLE. No starvation in mode 0.
- ACCESS, store (wmask != 0):
  - Lasts exactly 1 cycle.
  - Then mem_en_o = 0 and mem_wmask_o = 0, and state goes to IDLE.
  - No rvalid is produced; d_gnt_o serves as the store acknowledge.
- ACCESS, load or fetch:
  - mem_en_o is held high while the counter counts down.
  - On the edge where the counter is 0, mem_rdata_i is captured into the owner's rdata register, mem_en_o drops, and state goes to RESP.
  - ACCESS therefore lasts exactly RD_LATENCY cycles.
- RESP:
  - The owner's rvalid_o is high for one cycle with rdata_o valid.
  - Next state is IDLE.
  - The other port's rdata_o is unchanged.
- Requester rule: hold req and the request fields stable until gnt_o is seen high, then deassert req in the next cycle unless issuing a new request. req is ignored outside IDLE.
- mem_addr_o and mem_wdata_o hold their last values while idle.
- Throughput:
  - Store: 2 cycles per access (IDLE, ACCESS).
  - Read: RD_LATENCY + 2 cycles.
- Width rules:
  - Addresses are passed through as byte addresses; the RAM performs word indexing.
  - The counter is 3 bits.
  - RD_LATENCY=0 or RD_LATENCY>7 is illegal and is flagged by a simulation-time $error.

Test Plan:
1. Reset then idle: reset_n low 3 cycles, no requests -> all outputs 0, busy_o=0, mem_en_o never pulses.
2. Fetch read, RD_LATENCY=1: i_req_i with i_addr_i=32'h8, RAM word 2 = 32'hDEADBEEF -> i_gnt_o pulses in cycle 1, mem_en_o high 1 cycle with mem_addr_o=32'h8, i_rvalid_o one cycle later with i_rdata_o=32'hDEADBEEF.
3. Store then load: d_req_i with addr 32'h4, wdata 32'h000000AA, wmask 4'b0001 -> mem_en_o=1 and mem_wmask_o=4'b0001 for 1 cycle, no d_rvalid_o. Following load at 32'h4 -> d_rdata_o[7:0]=8'hAA.
4. Simultaneous requests, PRIO_MODE=0:
   - i_req_i and d_req_i held high together -> grants alternate D, I, D, I.
   - Both ports receive the correct data.
   - i_rdata_o is unaffected by data-port reads.
5. Fixed priority: PRIO_MODE=1 with d_req_i continuously high and i_req_i high -> only d_gnt_o pulses; after d_req_i drops, i_gnt_o pulses at the next IDLE.
6. Reset mid-read, RD_LATENCY=4: assert reset_n low in the 2nd ACCESS cycle -> mem_en_o drops immediately, no rvalid, FSM in IDLE after release, and the next request completes normally.
